a2d_arbiter: RTL

//  Shares the single A2D_intf SPI converter between two requesters. Port A is
//  the round-robin slider poller; port B is a high-priority on-demand client
//  (e.g. battery/aux monitor). Grants one owner at a time, issues strt_cnv and

---
 rtl/a2d_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/a2d_arbiter.sv
// -----------------------------------------------------------------------------
// a2d_arbiter
//   Shares one A2D_intf SPI converter between two requesters. Port A is the
//   round-robin slider poller; port B is a high-priority on-demand client.
//   One owner is granted at a time. The arbiter issues strt_cnv/chnnl to
//   A2D_intf and returns the result to the owner with a one-cycle done pulse.
//   B wins simultaneous requests, but A is forced through after MAX_CONSEC
//   consecutive B grants taken while A was waiting.
//
// Optional feature: define A2D_WDOG_EN to enable the WAIT-state watchdog.
//   After TIMEOUT_CYC cycles in WAIT the conversion is aborted. The result is
//   then 12'hFFF and timeout is raised together with the done pulse. Without
//   the macro, WAIT holds indefinitely and timeout is tied low.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_a, chnnl_a[2:0]  requester A: level request, channel sampled at grant
//   req_b, chnnl_b[2:0]  requester B: level request, channel sampled at grant
//   done_a, done_b       one-cycle completion pulse to the owner
//   result[11:0]         last conversion result, held until the next done
//   timeout              qualifies done_x: conversion aborted by watchdog
//   strt_cnv             one-cycle start pulse to A2D_intf
//   chnnl[2:0]           channel to A2D_intf, stable from START through WAIT
//   cnv_cmplt, res[11:0] completion flag and result from A2D_intf
// -----------------------------------------------------------------------------
module a2d_arbiter #(
   parameter int unsigned MAX_CONSEC  = 3,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_a,
   input  logic [2:0]  chnnl_a,
   input  logic        req_b,
   input  logic [2:0]  chnnl_b,
   output logic        done_a,
   output logic        done_b,
   output logic [11:0] result,
   output logic        timeout,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   input  logic        cnv_cmplt,
   input  logic [11:0] res
);

   localparam int unsigned CW = ($clog2(MAX_CONSEC + 1) < 1) ? 1 : $clog2(MAX_CONSEC + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_owner_b;
   logic [2:0]      r_chnnl;
   logic [11:0]     r_result;
   logic            r_timeout;
   logic [CW-1:0]   r_consec_b;
   logic            w_sat;
   logic            w_grant_a;
   logic            w_grant_b;
   logic            w_wdog_hit;

   // B wins a tie unless it has already taken MAX_CONSEC grants past a waiting A
   assign w_sat     = (r_consec_b == CW'(MAX_CONSEC));
   assign w_grant_b = req_b && !(req_a && w_sat);
   assign w_grant_a = req_a && !w_grant_b;

`ifdef A2D_WDOG_EN
   localparam int unsigned WW = ($clog2(TIMEOUT_CYC + 1) < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   logic [WW-1:0] r_wdog;

   // Cleared in START, so every WAIT phase begins counting from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_wdog <= '0;
      else if (r_state == S_START)
         r_wdog <= '0;
      else if (r_state == S_WAIT)
         r_wdog <= r_wdog + WW'(1);
   end

   assign w_wdog_hit = (r_state == S_WAIT) && (r_wdog == WW'(TIMEOUT_CYC - 1));
`else
   assign w_wdog_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant_a || w_grant_b) w_next = S_START;
         S_START: w_next = S_WAIT;
         S_WAIT:  if (cnv_cmplt || w_wdog_hit) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      strt_cnv = 1'b0;
      done_a   = 1'b0;
      done_b   = 1'b0;
      timeout  = 1'b0;
      case (r_state)
         S_START: strt_cnv = 1'b1;
         S_DONE: begin
            done_a  = !r_owner_b;
            done_b  = r_owner_b;
            timeout = r_timeout;
         end
         default: ;
      endcase
   end

   assign chnnl  = r_chnnl;
   assign result = r_result;

   // Grant bookkeeping and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner_b  <= 1'b0;
         r_chnnl    <= '0;
         r_result   <= '0;
         r_timeout  <= 1'b0;
         r_consec_b <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_a) begin
                  r_owner_b  <= 1'b0;
                  r_chnnl    <= chnnl_a;
                  r_consec_b <= '0;
               end else if (w_grant_b) begin
                  r_owner_b  <= 1'b1;
                  r_chnnl    <= chnnl_b;
                  // A B grant over a pending A is only possible below saturation
                  r_consec_b <= req_a ? (r_consec_b + CW'(1)) : '0;
               end
            end
            S_WAIT: begin
               // A completion in the expiry cycle takes priority over the watchdog
               if (cnv_cmplt) begin
                  r_result  <= res;
                  r_timeout <= 1'b0;
               end else if (w_wdog_hit) begin
                  r_result  <= 12'hFFF;
                  r_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
